ldtu_bsl_calib: RTL and testbench
=================================

Name: ldtu_bsl_calib

Overview:
- Baseline calibration sequencer for the LiTe-DTU baseline-subtraction stage.
- On request, waits a settle window, then averages 2^LOG2_NSAMP samples from each gain channel.
- Rounds and saturates each mean to 8 bits and loads it into the BSL_VAL_g01/BSL_VAL_g10 registers that feed the subtractor.
- A manual mode lets slow control force both baseline values.

Parameters:
- Nbits_12, 12: ADC sample width.
- Nbits_8, 8: baseline value width.
- LOG2_NSAMP, 6: log2 of the number of averaged samples (N = 64).
- SETTLE_CYC, 16: cycles ignored after start, before accumulation begins.

Ports:
- CLK  in  1: LiTe-DTU clock, the only clock of the block.
- rst_b  in  1: asynchronous, active-low reset.
- cal_start  in  1: single-cycle calibration request.
- cal_abort  in  1: cancels a calibration in progress.
- man_mode  in  1: 1 = outputs follow the manual values.
- BSL_MAN_g01  in  8: manual baseline value, gain 1.
- BSL_MAN_g10  in  8: manual baseline value, gain 10.
- DATA12_g01  in  12: gain-1 samples, synchronous to CLK.
- DATA12_g10  in  12: gain-10 samples, synchronous to CLK.
- sample_valid  in  1: qualifies DATA12_g01/g10 in the current cycle.
- BSL_VAL_g01  out  8: registered baseline value, gain 1.
- BSL_VAL_g10  out  8: registered baseline value, gain 10.
- cal_busy  out  1: high in SETTLE, ACCUM and UPDATE.
- cal_done  out  1: one-cycle pulse when new values are loaded.
- cal_ovf_g01  out  1: sticky flag, gain-1 mean exceeded 255.
- cal_ovf_g10  out  1: sticky flag, gain-10 mean exceeded 255.

Behaviour:
- Reset (rst_b=0, asynchronous): state IDLE; all counters and accumulators 0; all outputs 0.
- FSM states: IDLE, SETTLE, ACCUM, UPDATE.
- IDLE -> SETTLE: when cal_start=1, cal_abort=0 and man_mode=0. The settle counter clears and both ovf flags clear on the same edge.
- SETTLE: counts SETTLE_CYC cycles; data is ignored. -> ACCUM after SETTLE_CYC cycles.
- ACCUM: on each edge with sample_valid=1, adds each channel zero-extended into an 18-bit (Nbits_12+LOG2_NSAMP) accumulator and increments the sample counter. Accepting the N-th sample moves to UPDATE. sample_valid=0 stalls the FSM with no timeout.
- UPDATE (1 cycle):
  - mean = (acc + 2^(LOG2_NSAMP-1)) >> LOG2_NSAMP, i.e. round half up.
  - If mean > 255: load 255 and set the channel's ovf flag; otherwise load mean[7:0].
  - BSL_VAL regs load on the edge leaving UPDATE; cal_done=1 for the following cycle; next state IDLE.
- Latency: with sample_valid tied high, cal_done is high exactly SETTLE_CYC+N+2 cycles after the cycle in which cal_start was high (82 with defaults).
- cal_abort=1, or man_mode=1, in SETTLE/ACCUM/UPDATE -> IDLE next edge. BSL_VAL unchanged, no cal_done, ovf flags keep their current value.
- cal_start while cal_busy=1: ignored, not queued.
- cal_start and cal_abort together in IDLE: abort wins, no start.
- man_mode=1: BSL_VAL_g01/g10 load BSL_MAN_g01/g10 every edge (1-cycle latency); cal_start ignored.
- man_mode 1->0: BSL_VAL holds the last manual value until the next completed calibration.
- BSL_VAL outputs change only in UPDATE or in man_mode, never mid-accumulation, so the subtractor sees no intermediate values.
- Accumulator cannot overflow: 18 bits hold at most 64*4095.

Decomposition:
- Package ldtu_bsl_pkg: state encoding constants (IDLE=2'd0, SETTLE=2'd1, ACCUM=2'd2, UPDATE=2'd3), ACC_W = Nbits_12+LOG2_NSAMP, BSL_MAX = 8'd255.
- Sub-module ldtu_bsl_acc, instantiated once per gain: clear/enable 18-bit accumulator, round, saturate, ovf output.
- FSM and counters stay in the top.

Test Plan:
- Constant g01=12'd100, g10=12'd40, valid high, start -> BSL_VAL=100/40, cal_done exactly 82 cycles after start, ovf=0/0.
- g01=12'd300 constant -> BSL_VAL_g01=255, cal_ovf_g01=1, cal_ovf_g10=0; next calibration with g01=12'd50 -> 50 and ovf cleared.
- g01 alternating 10/11 -> sum 672, (672+32)>>6 = 11; g10 = 63x0 + 1x4095 -> (4095+32)>>6 = 64.
- Abort at cycle 30 after start (prior BSL=100/40); also abort with start in the same IDLE cycle -> no cal_done, values stay 100/40, cal_busy low next cycle.
- man_mode=1 with BSL_MAN_g01=8'h55, BSL_MAN_g10=8'hAA -> outputs 55/AA after 1 edge; start ignored; drop man_mode -> values hold.
- sample_valid 50% duty -> cal_done after SETTLE_CYC+128+2 cycles; rst_b low mid-ACCUM -> all outputs 0 immediately (asynchronous), FSM IDLE.

Source files
------------

// File: rtl/ldtu_bsl_pkg.sv
// Shared constants and state encoding for the baseline calibration sequencer.
// Widths derive from the ADC sample width and the averaging depth.
package ldtu_bsl_pkg;

  localparam int Nbits_12   = 12;
  localparam int Nbits_8    = 8;
  localparam int LOG2_NSAMP = 6;
  localparam int SETTLE_CYC = 16;
  localparam int ACC_W      = Nbits_12 + LOG2_NSAMP;

  localparam logic [Nbits_8-1:0] BSL_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    UPDATE = 2'd3
  } state_t;

endpackage

// File: rtl/ldtu_bsl_acc.sv
// Per-gain sample accumulator with round-half-up mean and 8-bit saturation.
// Accumulates on en, clears on clr; mean/ovf are combinational from the accumulator.
module ldtu_bsl_acc
  import ldtu_bsl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [Nbits_12-1:0] din,
  output logic [Nbits_8-1:0]  mean_sat,
  output logic                ovf
);

  localparam logic [ACC_W-1:0] HALF = ACC_W'(2 ** (LOG2_NSAMP - 1));

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mean_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(din);
    end
  end

  // 64*4095 + 32 still fits in ACC_W bits, so the rounding add cannot wrap
  assign mean_full = (acc + HALF) >> LOG2_NSAMP;
  assign ovf       = |mean_full[ACC_W-1:Nbits_8];
  assign mean_sat  = ovf ? BSL_MAX : mean_full[Nbits_8-1:0];

endmodule

// File: rtl/ldtu_bsl_calib.sv
// Baseline calibration sequencer: settle, average 2^LOG2_NSAMP samples per gain, load BSL_VAL.
// cal_done follows start by SETTLE_CYC+N+2 cycles when sample_valid stays high; gaps stall ACCUM.
module ldtu_bsl_calib
  import ldtu_bsl_pkg::*;
(
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                cal_start,
  input  logic                cal_abort,
  input  logic                man_mode,
  input  logic [Nbits_8-1:0]  BSL_MAN_g01,
  input  logic [Nbits_8-1:0]  BSL_MAN_g10,
  input  logic [Nbits_12-1:0] DATA12_g01,
  input  logic [Nbits_12-1:0] DATA12_g10,
  input  logic                sample_valid,
  output logic [Nbits_8-1:0]  BSL_VAL_g01,
  output logic [Nbits_8-1:0]  BSL_VAL_g10,
  output logic                cal_busy,
  output logic                cal_done,
  output logic                cal_ovf_g01,
  output logic                cal_ovf_g10
);

  localparam int SET_W = $clog2(SETTLE_CYC);
  localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [LOG2_NSAMP-1:0] SAMP_LAST   = '1;

  state_t                 state, state_nxt;
  logic [SET_W-1:0]       set_cnt;
  logic [LOG2_NSAMP-1:0]  samp_cnt;
  logic                   start;
  logic                   load;
  logic                   acc_clr;
  logic                   acc_en;
  logic [Nbits_8-1:0]     mean_g01, mean_g10;
  logic                   ovf_g01, ovf_g10;

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (cal_start && !cal_abort && !man_mode) begin
          state_nxt = SETTLE;
          start     = 1'b1;
        end
      end
      SETTLE: if (set_cnt == SETTLE_LAST) state_nxt = ACCUM;
      ACCUM:  if (sample_valid && samp_cnt == SAMP_LAST) state_nxt = UPDATE;
      UPDATE: begin
        state_nxt = IDLE;
        load      = !cal_abort && !man_mode;
      end
      default: state_nxt = IDLE;
    endcase
    // abort and manual override cancel any calibration without touching outputs
    if (state != IDLE && (cal_abort || man_mode)) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      set_cnt  <= '0;
      samp_cnt <= '0;
    end else begin
      if (start) begin
        set_cnt <= '0;
      end else if (state == SETTLE) begin
        set_cnt <= set_cnt + 1'b1;
      end
      if (state == SETTLE) begin
        samp_cnt <= '0;
      end else if (state == ACCUM && sample_valid) begin
        samp_cnt <= samp_cnt + 1'b1;
      end
    end
  end

  assign acc_clr  = (state == SETTLE);
  assign acc_en   = (state == ACCUM) && sample_valid;
  assign cal_busy = (state != IDLE);

  ldtu_bsl_acc u_acc_g01 (
    .clk      (CLK),
    .rst_n    (rst_b),
    .clr      (acc_clr),
    .en       (acc_en),
    .din      (DATA12_g01),
    .mean_sat (mean_g01),
    .ovf      (ovf_g01)
  );

  ldtu_bsl_acc u_acc_g10 (
    .clk      (CLK),
    .rst_n    (rst_b),
    .clr      (acc_clr),
    .en       (acc_en),
    .din      (DATA12_g10),
    .mean_sat (mean_g10),
    .ovf      (ovf_g10)
  );

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      BSL_VAL_g01 <= '0;
      BSL_VAL_g10 <= '0;
      cal_ovf_g01 <= 1'b0;
      cal_ovf_g10 <= 1'b0;
      cal_done    <= 1'b0;
    end else begin
      cal_done <= load;
      if (man_mode) begin
        BSL_VAL_g01 <= BSL_MAN_g01;
        BSL_VAL_g10 <= BSL_MAN_g10;
      end else if (load) begin
        BSL_VAL_g01 <= mean_g01;
        BSL_VAL_g10 <= mean_g10;
      end
      if (start) begin
        cal_ovf_g01 <= 1'b0;
        cal_ovf_g10 <= 1'b0;
      end else if (load) begin
        cal_ovf_g01 <= cal_ovf_g01 | ovf_g01;
        cal_ovf_g10 <= cal_ovf_g10 | ovf_g10;
      end
    end
  end

endmodule

// File: tb/tb_ldtu_bsl_calib.sv
// Bench for ldtu_bsl_calib: table of calibration vectors scored through an expectation queue,
// plus hand sequences for abort, manual mode and asynchronous reset.
module tb_ldtu_bsl_calib;

  logic        CLK = 1'b0;
  logic        rst_b;
  logic        cal_start, cal_abort, man_mode, sample_valid;
  logic [7:0]  BSL_MAN_g01, BSL_MAN_g10;
  logic [11:0] DATA12_g01, DATA12_g10;
  logic [7:0]  BSL_VAL_g01, BSL_VAL_g10;
  logic        cal_busy, cal_done, cal_ovf_g01, cal_ovf_g10;

  ldtu_bsl_calib dut (
    .CLK          (CLK),
    .rst_b        (rst_b),
    .cal_start    (cal_start),
    .cal_abort    (cal_abort),
    .man_mode     (man_mode),
    .BSL_MAN_g01  (BSL_MAN_g01),
    .BSL_MAN_g10  (BSL_MAN_g10),
    .DATA12_g01   (DATA12_g01),
    .DATA12_g10   (DATA12_g10),
    .sample_valid (sample_valid),
    .BSL_VAL_g01  (BSL_VAL_g01),
    .BSL_VAL_g10  (BSL_VAL_g10),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .cal_ovf_g01  (cal_ovf_g01),
    .cal_ovf_g10  (cal_ovf_g10)
  );

  always #5 CLK = ~CLK;

  localparam int SETTLE = 16;
  localparam int NSAMP  = 64;

  // sample k: k==NSAMP-1 -> l, else odd k -> b, even k -> a
  typedef struct {
    logic [11:0] a01, b01, l01, a10, b10, l10;
    logic [7:0]  e01, e10;
    logic        o01, o10;
    logic        half;
  } vec_t;

  typedef struct {
    logic [7:0] e01, e10;
    logic       o01, o10;
    int         lat;
  } exp_t;

  vec_t vec[7];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic [7:0] cur01 = 8'd0, cur10 = 8'd0;

  always @(negedge CLK) if (cal_done) done_cnt++;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic logic [11:0] sval(input logic [11:0] a, b, l, input int k);
    if (k == NSAMP - 1) return l;
    return (k % 2 == 1) ? b : a;
  endfunction

  task automatic run_cal(input vec_t v, input string tag);
    exp_t e;
    int   cyc, k, w;
    logic ph, vld;
    e.e01 = v.e01; e.e10 = v.e10; e.o01 = v.o01; e.o10 = v.o10;
    e.lat = v.half ? SETTLE + 2 * NSAMP + 2 : SETTLE + NSAMP + 2;
    exp_q.push_back(e);
    cal_start = 1'b1; sample_valid = 1'b1;
    DATA12_g01 = 12'hFFF; DATA12_g10 = 12'hFFF;
    tick; cyc = 1; cal_start = 1'b0;
    repeat (SETTLE) begin tick; cyc++; end
    k = 0; ph = 1'b0;
    while (k < NSAMP) begin
      vld = v.half ? ph : 1'b1;
      ph  = ~ph;
      sample_valid = vld;
      DATA12_g01 = vld ? sval(v.a01, v.b01, v.l01, k) : 12'hABC;
      DATA12_g10 = vld ? sval(v.a10, v.b10, v.l10, k) : 12'hABC;
      tick; cyc++;
      if (vld) begin
        k++;
        if (k == NSAMP / 2) begin
          chk({tag, "_hold01"}, BSL_VAL_g01, cur01);
          chk({tag, "_hold10"}, BSL_VAL_g10, cur10);
          chk({tag, "_busy"}, cal_busy, 1);
        end
      end
    end
    sample_valid = 1'b0;
    w = 0;
    while (!cal_done && w < 8) begin tick; cyc++; w++; end
    if (!cal_done) begin
      chk({tag, "_done_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_done"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_lat"}, cyc, e.lat);
      chk({tag, "_val01"}, BSL_VAL_g01, e.e01);
      chk({tag, "_val10"}, BSL_VAL_g10, e.e10);
      chk({tag, "_ovf01"}, cal_ovf_g01, e.o01);
      chk({tag, "_ovf10"}, cal_ovf_g10, e.o10);
      cur01 = e.e01; cur10 = e.e10;
    end
    tick;
    chk({tag, "_done_pulse"}, cal_done, 0);
    chk({tag, "_idle"}, cal_busy, 0);
  endtask

  initial begin
    int d0;
    //           a01    b01    l01    a10    b10    l10     e01     e10    o01   o10   half
    vec[0] = '{12'd100, 12'd100, 12'd100, 12'd40, 12'd40, 12'd40,   8'd100, 8'd40, 1'b0, 1'b0, 1'b0};
    vec[1] = '{12'd300, 12'd300, 12'd300, 12'd40, 12'd40, 12'd40,   8'd255, 8'd40, 1'b1, 1'b0, 1'b0};
    vec[2] = '{12'd50,  12'd50,  12'd50,  12'd40, 12'd40, 12'd40,   8'd50,  8'd40, 1'b0, 1'b0, 1'b0};
    vec[3] = '{12'd10,  12'd11,  12'd11,  12'd0,  12'd0,  12'd4095, 8'd11,  8'd64, 1'b0, 1'b0, 1'b0};
    vec[4] = '{12'd0,   12'd1,   12'd1,   12'd0,  12'd0,  12'd31,   8'd1,   8'd0,  1'b0, 1'b0, 1'b0};
    vec[5] = '{12'd255, 12'd255, 12'd255, 12'd256, 12'd256, 12'd256, 8'd255, 8'd255, 1'b0, 1'b1, 1'b0};
    vec[6] = '{12'd100, 12'd100, 12'd100, 12'd40, 12'd40, 12'd40,   8'd100, 8'd40, 1'b0, 1'b0, 1'b1};

    rst_b = 1'b0; cal_start = 1'b0; cal_abort = 1'b0; man_mode = 1'b0; sample_valid = 1'b0;
    BSL_MAN_g01 = 8'd0; BSL_MAN_g10 = 8'd0; DATA12_g01 = 12'd0; DATA12_g10 = 12'd0;
    #12;
    chk("rst_val01", BSL_VAL_g01, 0);
    chk("rst_val10", BSL_VAL_g10, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_done", cal_done, 0);
    chk("rst_ovf01", cal_ovf_g01, 0);
    chk("rst_ovf10", cal_ovf_g10, 0);
    @(negedge CLK); rst_b = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) run_cal(vec[i], $sformatf("vec%0d", i));

    // abort in the middle of accumulation
    d0 = done_cnt;
    DATA12_g01 = 12'd200; DATA12_g10 = 12'd200; sample_valid = 1'b1;
    cal_start = 1'b1; tick; cal_start = 1'b0;
    repeat (29) tick;
    cal_abort = 1'b1; tick; cal_abort = 1'b0;
    chk("abort_busy", cal_busy, 0);
    repeat (100) tick;
    chk("abort_no_done", done_cnt, d0);
    chk("abort_val01", BSL_VAL_g01, cur01);
    chk("abort_val10", BSL_VAL_g10, cur10);

    // start and abort in the same idle cycle
    cal_start = 1'b1; cal_abort = 1'b1; tick;
    cal_start = 1'b0; cal_abort = 1'b0;
    chk("start_abort_busy", cal_busy, 0);
    repeat (90) tick;
    chk("start_abort_no_done", done_cnt, d0);
    chk("start_abort_val01", BSL_VAL_g01, cur01);
    sample_valid = 1'b0;

    // manual override
    man_mode = 1'b1; BSL_MAN_g01 = 8'h55; BSL_MAN_g10 = 8'hAA; tick;
    chk("man_val01", BSL_VAL_g01, 8'h55);
    chk("man_val10", BSL_VAL_g10, 8'hAA);
    cal_start = 1'b1; tick; cal_start = 1'b0;
    chk("man_start_ignored", cal_busy, 0);
    BSL_MAN_g01 = 8'h12; BSL_MAN_g10 = 8'h34; tick;
    chk("man_follow01", BSL_VAL_g01, 8'h12);
    chk("man_follow10", BSL_VAL_g10, 8'h34);
    man_mode = 1'b0; BSL_MAN_g01 = 8'h00; BSL_MAN_g10 = 8'h00;
    repeat (5) tick;
    chk("man_hold01", BSL_VAL_g01, 8'h12);
    chk("man_hold10", BSL_VAL_g10, 8'h34);
    chk("man_no_done", done_cnt, d0);
    cur01 = 8'h12; cur10 = 8'h34;

    // asynchronous reset in the middle of accumulation, with outputs and a flag set
    run_cal(vec[5], "pre_reset");
    d0 = done_cnt;
    DATA12_g01 = 12'd77; DATA12_g10 = 12'd77; sample_valid = 1'b1;
    cal_start = 1'b1; tick; cal_start = 1'b0;
    repeat (40) tick;
    #2 rst_b = 1'b0;
    #1;
    chk("arst_val01", BSL_VAL_g01, 0);
    chk("arst_val10", BSL_VAL_g10, 0);
    chk("arst_ovf10", cal_ovf_g10, 0);
    chk("arst_busy", cal_busy, 0);
    @(negedge CLK); rst_b = 1'b1;
    repeat (100) tick;
    chk("arst_idle", cal_busy, 0);
    chk("arst_no_done", done_cnt, d0);
    sample_valid = 1'b0;
    cur01 = 8'd0; cur10 = 8'd0;
    run_cal(vec[0], "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
